// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity encoding and oversample default
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN       = 1'b0;
    localparam logic PAR_ODD        = 1'b1;
    localparam int   PAR_EN         = 1;
    localparam int   OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with parameterized reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver; macro UART_RX_PARITY_EN enables the parity bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [1:0] parity,
    input  logic       fifowrfull,
    output logic       fifowrreq,
    output logic [7:0] fifodata,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

`ifdef UART_RX_PARITY_EN
    localparam logic PARITY_ON = 1'b1;
`else
    localparam logic PARITY_ON = 1'b0;
`endif

    localparam int            CW   = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic          rxs;
    logic          rxs_prev;
    uart_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bitn, bitn_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          chk, chk_nx;
    logic          perr, perr_nx;
    logic          wr_nx, ferr_nx, pe_nx, ovr_nx;
    logic [7:0]    data_nx;
    logic          par_en;
    logic          chk_init;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    assign par_en   = PARITY_ON & parity[PAR_EN];
    assign chk_init = PARITY_ON & (parity[0] == PAR_ODD);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        bitn_nx  = bitn;
        shreg_nx = shreg;
        chk_nx   = chk;
        perr_nx  = perr;
        wr_nx    = 1'b0;
        ferr_nx  = 1'b0;
        pe_nx    = 1'b0;
        ovr_nx   = 1'b0;
        data_nx  = fifodata;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                // A true high-to-low transition is required, so a held break cannot retrigger.
                if (rxs_prev && !rxs) begin
                    state_nx = ST_START;
                    bitn_nx  = 3'd0;
                    chk_nx   = chk_init;
                    perr_nx  = 1'b0;
                end
            end
            ST_START: begin
                if (cnt == HALF) begin
                    cnt_nx   = '0;
                    state_nx = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == LAST) begin
                    cnt_nx   = '0;
                    shreg_nx = {rxs, shreg[7:1]};
                    chk_nx   = chk ^ rxs;
                    bitn_nx  = bitn + 3'd1;
                    if (bitn == 3'd7)
                        state_nx = par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (cnt == LAST) begin
                    cnt_nx   = '0;
                    perr_nx  = (rxs != chk);
                    state_nx = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == LAST) begin
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                    if (!rxs)
                        ferr_nx = 1'b1;
                    else if (perr && PARITY_ON)
                        pe_nx = 1'b1;
                    else if (fifowrfull)
                        ovr_nx = 1'b1;
                    else begin
                        wr_nx   = 1'b1;
                        data_nx = shreg;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bitn       <= 3'd0;
            shreg      <= 8'h00;
            chk        <= 1'b0;
            perr       <= 1'b0;
            rxs_prev   <= 1'b1;
            fifowrreq  <= 1'b0;
            fifodata   <= 8'h00;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            bitn       <= bitn_nx;
            shreg      <= shreg_nx;
            chk        <= chk_nx;
            perr       <= perr_nx;
            rxs_prev   <= rxs;
            fifowrreq  <= wr_nx;
            fifodata   <= data_nx;
            parity_err <= pe_nx;
            frame_err  <= ferr_nx;
            overrun    <= ovr_nx;
        end
    end

endmodule
